axi_slice_rr_arbiter: RTL and testbench
=======================================

# axi_slice_rr_arbiter

Round-robin arbiter that merges `NUM_REQ` valid/ready request channels into one registered output channel. It sits in front of an AXI channel slice wherever several masters or ports share one AW, AR or W path. The block selects one requester per transfer with fair rotating priority. It tags the transfer with the winner's index and holds the result in a single-entry output register, so the shared path sees a registered, AXI-stable channel.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 64: payload width per requester.
- `IDX_WIDTH`, default `$clog2(NUM_REQ)`: derived; never overridden.

Ports (single clock `clk_i`; reset `rst_ni` is asynchronous, active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `valid_i`  in  NUM_REQ  per-requester valid.
- `ready_o`  out  NUM_REQ  per-requester ready; one-hot or zero.
- `data_i`  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `valid_o`  out  1  output register holds a transfer.
- `ready_i`  in  1  downstream accepts.
- `data_o`  out  DATA_WIDTH  registered payload.
- `idx_o`  out  IDX_WIDTH  registered index of the requester that produced `data_o`.

## Operation
- State:
  - output register (`full`, data, idx);
  - priority pointer `prio` (IDX_WIDTH bits).
- `load_en = ~full | (ready_i & valid_o)`. The register accepts a new entry when empty, or in the same cycle it is popped.
- Grant `g`:
  - the first k with `valid_i[k]=1`, scanning k = prio, prio+1, …, NUM_REQ-1, 0, …, prio-1;
  - computed combinationally every cycle.
- `ready_o[g] = load_en & |valid_i`. All other `ready_o` bits are 0. `ready_o` never depends on `ready_i` except through `load_en`.
- On handshake (`valid_i[g] & ready_o[g]`):
  - data register ← `data_i[g]`;
  - idx register ← g;
  - `full` ← 1;
  - `prio` ← g+1, wrapping NUM_REQ-1 → 0.
- On pop without push: `full` ← 0; data and idx registers hold their last value.
- Push and pop in the same cycle: register is replaced, `full` stays 1, and output throughput is 1 transfer/cycle.
- No push: `prio` is unchanged. Idle cycles do not rotate priority.
- Fairness: a requester holding `valid_i` high is granted within NUM_REQ-1 other grants.
- AXI stability: while `valid_o=1 & ready_i=0`, `data_o`, `idx_o` and `valid_o` are frozen.
- Requesters may drop `valid_i` before being granted. The arbiter has no lock on a requester until its handshake completes.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `idx_o`=0, `prio`=0, `full`=0. `ready_o` is combinational, so it is 0 only while all `valid_i`=0.
- Latency: input handshake in cycle n gives `valid_o`=1 with that payload in cycle n+1.
- Throughput: 1 transfer per cycle with `ready_i` held high and any requester valid.
- Full, no pop: all `ready_o`=0 regardless of `valid_i`.
- Full with pop: `ready_o[g]` may assert in the same cycle; this is the zero-bubble path.
- Reset asserted mid-transfer: the output register is cleared immediately (asynchronously), and the in-flight entry is discarded without a handshake. `prio` returns to 0.
- Combinational paths:
  - `valid_i` → `ready_o`;
  - `ready_i` → `ready_o`.
- Paths that do not exist: no combinational path from `valid_i` or `data_i` to `valid_o`, `data_o` or `idx_o`.

## Test plan
- Reset then single requester: `valid_i`=4'b0100 with data 0xA5 in cycle 0 → `ready_o`=4'b0100 in cycle 0; `valid_o`=1, `data_o`=0xA5, `idx_o`=2 in cycle 1; `prio`=3.
- All four valid continuously, `ready_i`=1: grants 0,1,2,3,0,1 on consecutive cycles; `idx_o` sequence is 0,1,2,3,… one cycle later; no bubbles.
- Backpressure: output full, `ready_i`=0 for 5 cycles → `data_o`/`idx_o` stable and all `ready_o`=0. Raising `ready_i` → pop and next push occur in the same cycle.
- Wrap-around: `prio`=3 with `valid_i`=4'b0011 → grant 0, `prio`←1; next cycle grant 1.
- Idle fairness: grant 2, then 3 idle cycles, then `valid_i`=4'b1111 → grant 3 (`prio` not advanced while idle).
- Reset mid-operation: `rst_ni` low while `valid_o`=1 and `ready_i`=0 → `valid_o`=0 and `data_o`=0 immediately; after release, the first grant follows order from `prio`=0.

Source files
------------

// File: rtl/axi_slice_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_slice_rr_arbiter
//
// Merges NUM_REQ valid/ready request channels into one registered output
// channel. Each transfer goes to one requester under rotating round-robin
// priority. The winning payload and the winner's index are captured in a
// single-entry output register, so the downstream AXI slice sees a registered
// channel that stays stable while it is stalled.
//
// Ports:
//   clk_i    in   1                    clock
//   rst_ni   in   1                    asynchronous active-low reset
//   valid_i  in   NUM_REQ              per-requester valid
//   ready_o  out  NUM_REQ              per-requester ready (one-hot or zero)
//   data_i   in   NUM_REQ*DATA_WIDTH   flattened payloads, requester k at
//                                      [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o  out  1                    output register holds a transfer
//   ready_i  in   1                    downstream accepts
//   data_o   out  DATA_WIDTH           registered payload
//   idx_o    out  IDX_WIDTH            index of requester that produced data_o
// -----------------------------------------------------------------------------
module axi_slice_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              valid_i,
  output logic [NUM_REQ-1:0]              ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [IDX_WIDTH-1:0]            idx_o
);

  // One extra bit so prio + offset never overflows before the wrap.
  localparam int unsigned SUM_W = IDX_WIDTH + 1;

  // First set bit of req scanning upward from start and wrapping past
  // NUM_REQ-1. Returns start when req is empty; the caller gates on |req.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   req,
    input logic [IDX_WIDTH-1:0] start
  );
    logic [IDX_WIDTH-1:0] pick;
    logic [SUM_W-1:0]     pos;
    logic                 found;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, start} + SUM_W'(i);
      if (pos >= SUM_W'(NUM_REQ)) begin
        pos = pos - SUM_W'(NUM_REQ);
      end
      if (!found && req[pos[IDX_WIDTH-1:0]]) begin
        pick  = pos[IDX_WIDTH-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index that follows idx in round-robin order.
  function automatic logic [IDX_WIDTH-1:0] rr_next(input logic [IDX_WIDTH-1:0] idx);
    logic [IDX_WIDTH-1:0] nxt;
    if (idx == IDX_WIDTH'(NUM_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_WIDTH'(1);
    end
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic [IDX_WIDTH-1:0]  prio;
  logic [IDX_WIDTH-1:0]  gnt_p0;
  logic                  any_vld_p0;
  logic                  load_en_p0;
  logic                  push_p0;
  logic                  pop_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [IDX_WIDTH-1:0]  idx_p1;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---- p0: arbitration (combinational, sees current prio and register state)
  // The register can take a new entry when empty or when it is being popped
  // this same cycle; the latter gives the zero-bubble path.
  assign any_vld_p0 = |valid_i;
  assign gnt_p0     = rr_pick(valid_i, prio);
  assign pop_p0     = vld_p1 & ready_i;
  assign load_en_p0 = ~vld_p1 | pop_p0;
  assign push_p0    = load_en_p0 & any_vld_p0;

  always_comb begin
    ready_o = '0;
    if (push_p0) begin
      ready_o[gnt_p0] = 1'b1;
    end
  end

  // ---- p1: output register and priority pointer
  // Priority only moves on a push, so idle cycles leave the next turn intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      prio    <= '0;
    end else if (push_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_arr[gnt_p0];
      idx_p1  <= gnt_p0;
      prio    <= rr_next(gnt_p0);
    end else if (pop_p0) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid_o = vld_p1;
  assign data_o  = data_p1;
  assign idx_o   = idx_p1;

endmodule

// File: tb/tb_axi_slice_rr_arbiter.sv
module tb_axi_slice_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    ready_o;
  logic [N*DW-1:0] data_i;
  logic            valid_o;
  logic            ready_i;
  logic [DW-1:0]   data_o;
  logic [1:0]      idx_o;

  always #5 clk_i = ~clk_i;

  axi_slice_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .idx_o  (idx_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    i;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_prio = 0;
  bit   m_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotating-priority choice: first valid requester at or after m_prio.
  function automatic int ref_grant(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(m_prio + i) % N]) return (m_prio + i) % N;
    end
    return -1;
  endfunction

  // Reference model: predicts ready_o and enqueues the expected output entry.
  always begin
    int g;
    logic [N-1:0] exp_rdy;
    bit load_en;
    bit popped;
    @(negedge clk_i);
    #1;
    if (rst_ni) begin
      popped  = m_full && ready_i;
      load_en = !m_full || ready_i;
      g       = ref_grant(valid_i);
      exp_rdy = '0;
      if (load_en && g >= 0) exp_rdy[g] = 1'b1;
      check("ready_o", 64'(ready_o), 64'(exp_rdy));
      if (load_en && g >= 0) begin
        q.push_back('{d: data_i[g*DW +: DW], i: g[1:0]});
        m_prio = (g + 1) % N;
        m_full = 1'b1;
      end else if (popped) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares output entries as the downstream consumes them.
  always begin
    exp_t e;
    bit hold;
    logic [DW-1:0] h_d;
    logic [1:0] h_i;
    @(negedge clk_i);
    if (!rst_ni) begin
      hold = 1'b0;
    end else begin
      check("valid_o", 64'(valid_o), 64'(q.size() != 0));
      if (hold) begin
        check("hold_data", data_o, h_d);
        check("hold_idx", 64'(idx_o), 64'(h_i));
      end
      if (valid_o && ready_i && q.size() > 0) begin
        e = q.pop_front();
        check("data_o", data_o, e.d);
        check("idx_o", 64'(idx_o), 64'(e.i));
      end
      hold = valid_o && !ready_i;
      h_d  = data_o;
      h_i  = idx_o;
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic r);
    valid_i = v;
    ready_i = r;
    for (int k = 0; k < N; k++) data_i[k*DW +: DW] = {$urandom, $urandom};
  endtask

  task automatic step(input logic [N-1:0] v, input logic r);
    @(posedge clk_i);
    #1;
    drive(v, r);
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = '0;
    ready_i = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_data_o", data_o, 64'd0);
    check("rst_idx_o", 64'(idx_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd0);
    rst_ni = 1'b1;

    // Single requester with a known payload.
    step(4'b0100, 1'b0);
    data_i[2*DW +: DW] = 64'hA5;
    #1;
    check("single_ready", 64'(ready_o), 64'b0100);
    step(4'b0000, 1'b0);
    #1;
    check("single_valid_o", 64'(valid_o), 64'd1);
    check("single_data_o", data_o, 64'hA5);
    check("single_idx_o", 64'(idx_o), 64'd2);
    step(4'b0000, 1'b1);

    // All requesters valid with a free-running consumer.
    repeat (8) step(4'b1111, 1'b1);

    // Backpressure, then release.
    repeat (5) step(4'b1111, 1'b0);
    repeat (3) step(4'b1111, 1'b1);

    // Wrap-around from prio=3.
    step(4'b0100, 1'b1);
    step(4'b0011, 1'b1);
    #1;
    check("wrap_first", 64'(ready_o), 64'b0001);
    step(4'b0011, 1'b1);
    #1;
    check("wrap_second", 64'(ready_o), 64'b0010);

    // Idle cycles do not rotate priority.
    step(4'b0100, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    step(4'b1111, 1'b1);
    #1;
    check("idle_fair", 64'(ready_o), 64'b1000);

    // Random traffic.
    repeat (400) step(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);

    // Reset while a stalled entry is held.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid_o", 64'(valid_o), 64'd0);
    check("midrst_data_o", data_o, 64'd0);
    check("midrst_idx_o", 64'(idx_o), 64'd0);
    q.delete();
    m_full = 1'b0;
    m_prio = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(4'b1111, 1'b1);
    #1;
    check("post_rst_grant", 64'(ready_o), 64'b0001);

    repeat (300) step(N'($urandom_range(0, 15)), $urandom_range(0, 1) != 0);
    step(4'b0000, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
